// File: rtl/fifo_read_rr_arbiter_if.sv
// Bundle of the FIFO read handshake and per-consumer signals for the
// round-robin FIFO read arbiter. The slave modport is the arbiter's view;
// the master modport is the view of whatever drives it.
interface fifo_read_rr_arbiter_if #(
    parameter int NUM_CONS       = 4,
    parameter int DATA_W         = 32,
    parameter int BURST_CNT_BITS = 5
);
    logic                      i_fifo_valid;
    logic [DATA_W-1:0]         i_fifo_data;
    logic                      o_fifo_dready;
    logic [NUM_CONS-1:0]       i_req;
    logic [NUM_CONS-1:0]       i_cons_dready;
    logic [NUM_CONS-1:0]       o_cons_valid;
    logic [DATA_W-1:0]         o_cons_data;
    logic [NUM_CONS-1:0]       o_grant;
    logic                      o_busy;
    logic [BURST_CNT_BITS-1:0] o_beat_cnt;

    modport slave (
        input  i_fifo_valid, i_fifo_data, i_req, i_cons_dready,
        output o_fifo_dready, o_cons_valid, o_cons_data, o_grant, o_busy, o_beat_cnt
    );

    modport master (
        output i_fifo_valid, i_fifo_data, i_req, i_cons_dready,
        input  o_fifo_dready, o_cons_valid, o_cons_data, o_grant, o_busy, o_beat_cnt
    );
endinterface

// File: rtl/fifo_read_rr_arbiter.sv
// Round-robin, burst-limited sharing of one FIFO read port among NUM_CONS
// consumers. Data is routed combinationally; the grant is registered and
// sequenced IDLE -> BURST -> RELEASE -> IDLE.
module fifo_read_rr_arbiter #(
    parameter int NUM_CONS       = 4,
    parameter int DATA_W         = 32,
    parameter int BURST_MAX      = 16,
    parameter int BURST_CNT_BITS = 5
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst_n,
    fifo_read_rr_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_CONS > 1) ? $clog2(NUM_CONS) : 1;
    localparam logic [PTR_W:0] NC_W = (PTR_W + 1)'(NUM_CONS);
    localparam logic [BURST_CNT_BITS-1:0] LAST_BEAT = BURST_CNT_BITS'(BURST_MAX - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BURST   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]                r_state;
    logic [NUM_CONS-1:0]       r_grant;
    logic [PTR_W-1:0]          r_gidx;
    logic [PTR_W-1:0]          r_rr_ptr;
    logic [BURST_CNT_BITS-1:0] r_beat_cnt;

    logic [PTR_W-1:0]    w_cand [NUM_CONS];
    logic [PTR_W-1:0]    w_next_idx;
    logic [NUM_CONS-1:0] w_next_onehot;
    logic                w_any_req;
    logic [PTR_W:0]      w_ptr_inc;
    logic [PTR_W-1:0]    w_ptr_next;
    logic                w_in_burst;
    logic                w_req_g;
    logic                w_rdy_g;
    logic                w_pop;
    logic                w_beat;
    logic                w_end_burst;
    logic [DATA_W-1:0]   w_data;

    // Candidate index at each round-robin offset from the pointer, wrapped mod NUM_CONS
    genvar gi;
    for (gi = 0; gi < NUM_CONS; gi++) begin : g_cand
        logic [PTR_W:0] w_sum;
        assign w_sum      = {1'b0, r_rr_ptr} + (PTR_W + 1)'(gi);
        assign w_cand[gi] = (w_sum >= NC_W) ? PTR_W'(w_sum - NC_W) : PTR_W'(w_sum);
    end

    // Pick the requester closest to the pointer; scanning backwards lets the nearest win
    always_comb begin
        w_next_idx = '0;
        for (int k = NUM_CONS - 1; k >= 0; k--) begin
            if (bus.i_req[w_cand[k]]) begin
                w_next_idx = w_cand[k];
            end
        end
    end

    for (gi = 0; gi < NUM_CONS; gi++) begin : g_onehot
        assign w_next_onehot[gi] = (w_next_idx == PTR_W'(gi));
    end

    assign w_any_req  = |bus.i_req;
    assign w_ptr_inc  = {1'b0, r_gidx} + (PTR_W + 1)'(1);
    assign w_ptr_next = (w_ptr_inc >= NC_W) ? '0 : PTR_W'(w_ptr_inc);

    // Handshake steering for the granted consumer; everything is gated off outside BURST
    assign w_in_burst  = (r_state == S_BURST);
    assign w_req_g     = bus.i_req[r_gidx];
    assign w_rdy_g     = bus.i_cons_dready[r_gidx];
    assign w_pop       = w_in_burst & w_req_g & w_rdy_g;
    assign w_beat      = w_pop & bus.i_fifo_valid;
    assign w_end_burst = (w_beat && (r_beat_cnt == LAST_BEAT)) || !w_req_g;

    assign w_data            = bus.i_fifo_data;
    assign bus.o_cons_data   = w_data;
    assign bus.o_fifo_dready = w_pop;
    assign bus.o_cons_valid  = r_grant & {NUM_CONS{w_in_burst & bus.i_fifo_valid & w_req_g}};
    assign bus.o_grant       = r_grant;
    assign bus.o_busy        = (r_state == S_BURST) || (r_state == S_RELEASE);
    assign bus.o_beat_cnt    = r_beat_cnt;

    // Grant sequencing: arbitrate in IDLE, count beats in BURST, advance pointer in RELEASE
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= S_BURST;
                        r_grant    <= w_next_onehot;
                        r_gidx     <= w_next_idx;
                        r_beat_cnt <= '0;
                    end
                end
                S_BURST: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + BURST_CNT_BITS'(1);
                    end
                    if (w_end_burst) begin
                        r_state <= S_RELEASE;
                        r_grant <= '0;
                    end
                end
                S_RELEASE: begin
                    r_rr_ptr   <= w_ptr_next;
                    r_beat_cnt <= '0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_read_rr_arbiter.sv
// Self-checking bench for fifo_read_rr_arbiter: a vector table, hand-written
// multi-cycle sequences and a randomized run against a grant-session model.
module tb_fifo_read_rr_arbiter;
    localparam int NC = 4;
    localparam int DW = 32;
    localparam int BM = 16;
    localparam int CB = 5;

    logic rd_clk   = 1'b0;
    logic rd_rst_n = 1'b1;
    always #5 rd_clk = ~rd_clk;

    fifo_read_rr_arbiter_if #(.NUM_CONS(NC), .DATA_W(DW), .BURST_CNT_BITS(CB)) bus ();

    fifo_read_rr_arbiter #(
        .NUM_CONS(NC), .DATA_W(DW), .BURST_MAX(BM), .BURST_CNT_BITS(CB)
    ) dut (
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    int wptr   = 0;

    typedef struct {
        logic [3:0] req;
        logic       fv;
        logic [3:0] rdy;
        logic [3:0] g;
        logic       d;
        logic [3:0] v;
        logic [4:0] c;
        logic       b;
    } vec_t;
    vec_t tbl [13];

    // grant-session reference model
    int m_owner, m_beats, m_rel, m_last, m_ptr;

    // observation results of run_obs
    logic [3:0] obs_g [8];
    int obs_beats [8];
    int obs_len [8];
    int obs_gap [8];
    int obs_n, obs_first, obs_viol;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic [3:0] eg, input logic ed,
                              input logic [3:0] ev, input logic [4:0] ec, input logic eb);
        logic [14:0] a;
        logic [14:0] e;
        a = {bus.o_grant, bus.o_fifo_dready, bus.o_cons_valid, bus.o_beat_cnt, bus.o_busy};
        e = {eg, ed, ev, ec, eb};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual g=%b d=%b v=%b c=%0d b=%b required g=%b d=%b v=%b c=%0d b=%b",
                     nm, bus.o_grant, bus.o_fifo_dready, bus.o_cons_valid, bus.o_beat_cnt,
                     bus.o_busy, eg, ed, ev, ec, eb);
        end
    endtask

    task automatic set_in(input logic [3:0] req, input logic fv, input logic [3:0] rdy);
        bus.i_req         = req;
        bus.i_fifo_valid  = fv;
        bus.i_cons_dready = rdy;
        bus.i_fifo_data   = 32'hD000_0000 + 32'(wptr);
    endtask

    task automatic next_cycle();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(4'h0, 1'b0, 4'h0);
        rd_rst_n = 1'b0;
        #1;
        check_outs("reset_state", 4'h0, 1'b0, 4'h0, 5'd0, 1'b0);
        repeat (2) @(posedge rd_clk);
        #3;
        rd_rst_n = 1'b1;
    endtask

    task automatic model_reset();
        m_owner = -1; m_beats = 0; m_rel = 0; m_last = 0; m_ptr = 0;
    endtask

    task automatic model_eval(input logic [3:0] req, input logic fv, input logic [3:0] rdy,
                              output logic [3:0] eg, output logic ed, output logic [3:0] ev,
                              output logic [4:0] ec, output logic eb);
        eg = 4'h0; ed = 1'b0; ev = 4'h0;
        if (m_owner >= 0) begin
            eg = 4'(1 << m_owner);
            ed = req[m_owner] & rdy[m_owner];
            ev = (req[m_owner] && fv) ? eg : 4'h0;
        end
        ec = 5'(m_beats);
        eb = (m_owner >= 0) || (m_rel != 0);
    endtask

    task automatic model_step(input logic [3:0] req, input logic fv, input logic [3:0] rdy);
        logic pop;
        if (m_owner >= 0) begin
            pop = req[m_owner] & rdy[m_owner] & fv;
            if (pop) m_beats++;
            if ((pop && m_beats == BM) || !req[m_owner]) begin
                $display("rand grant consumer %0d ended after %0d beats", m_owner, m_beats);
                m_last  = m_owner;
                m_owner = -1;
                m_rel   = 1;
            end
        end else if (m_rel != 0) begin
            m_rel   = 0;
            m_ptr   = (m_last + 1) % NC;
            m_beats = 0;
        end else if (req != 4'h0) begin
            for (int k = 0; k < NC; k++) begin
                if (req[(m_ptr + k) % NC]) begin
                    m_owner = (m_ptr + k) % NC;
                    break;
                end
            end
            m_beats = 0;
        end
    endtask

    // FIFO always valid, fixed requests; records each completed grant
    task automatic run_obs(input logic [3:0] req, input bit toggle, input int want, input int bound);
        logic [3:0] g, prev, rdy;
        int beats, len, zrun;
        obs_n = 0; obs_first = -1; obs_viol = 0;
        prev = 4'h0; beats = 0; len = 0; zrun = 0;
        for (int cyc = 0; cyc < bound && obs_n < want; cyc++) begin
            rdy = (toggle && (cyc % 2 == 1)) ? 4'h0 : 4'hF;
            next_cycle();
            set_in(req, 1'b1, rdy);
            #1;
            g = bus.o_grant;
            if (bus.o_fifo_dready !== ((g != 4'h0) ? |(g & req & rdy) : 1'b0)) obs_viol++;
            if (bus.o_cons_valid !== (g & req)) obs_viol++;
            if (g != 4'h0) begin
                if (prev == 4'h0) begin
                    if (obs_first < 0) obs_first = cyc;
                    obs_g[obs_n]   = g;
                    obs_gap[obs_n] = zrun;
                    beats = 0;
                    len   = 0;
                end
                len++;
                if (bus.o_fifo_dready && bus.i_fifo_valid) begin
                    check("pop_data", bus.o_cons_data, bus.i_fifo_data);
                    wptr++;
                    beats++;
                end
            end else begin
                if (prev != 4'h0) begin
                    obs_beats[obs_n] = beats;
                    obs_len[obs_n]   = len;
                    $display("grant %b: %0d beats over %0d cycles, gap before %0d",
                             obs_g[obs_n], beats, len, obs_gap[obs_n]);
                    obs_n++;
                    zrun = 0;
                end
                zrun++;
            end
            prev = g;
        end
        check("obs_complete", obs_n, want);
    endtask

    initial begin
        logic [3:0] eg, ev, reqv, rdy;
        logic       ed, eb, fv, hit;
        logic [4:0] ec;
        int         bad;

        // req fv rdy | grant dready valid cnt busy
        tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 5'd0, 1'b0};
        tbl[1]  = '{4'b0101, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 5'd0, 1'b0};
        tbl[2]  = '{4'b0101, 1'b1, 4'b1111, 4'b0001, 1'b1, 4'b0001, 5'd0, 1'b1};
        tbl[3]  = '{4'b0101, 1'b1, 4'b1111, 4'b0001, 1'b1, 4'b0001, 5'd1, 1'b1};
        tbl[4]  = '{4'b0101, 1'b0, 4'b1111, 4'b0001, 1'b1, 4'b0000, 5'd2, 1'b1};
        tbl[5]  = '{4'b0101, 1'b1, 4'b1110, 4'b0001, 1'b0, 4'b0001, 5'd2, 1'b1};
        tbl[6]  = '{4'b0100, 1'b1, 4'b1111, 4'b0001, 1'b0, 4'b0000, 5'd2, 1'b1};
        tbl[7]  = '{4'b0100, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 5'd2, 1'b1};
        tbl[8]  = '{4'b0100, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 5'd0, 1'b0};
        tbl[9]  = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 4'b0100, 5'd0, 1'b1};
        tbl[10] = '{4'b0000, 1'b1, 4'b1111, 4'b0100, 1'b0, 4'b0000, 5'd1, 1'b1};
        tbl[11] = '{4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 5'd1, 1'b1};
        tbl[12] = '{4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 5'd0, 1'b0};

        #1;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            set_in(tbl[i].req, tbl[i].fv, tbl[i].rdy);
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].g, tbl[i].d, tbl[i].v, tbl[i].c, tbl[i].b);
            $display("vec %0d req=%b fv=%b rdy=%b grant=%b cnt=%0d", i, tbl[i].req,
                     tbl[i].fv, tbl[i].rdy, bus.o_grant, bus.o_beat_cnt);
        end

        // single requester: latency, 16 pops, 2-cycle re-grant gap
        do_reset();
        run_obs(4'b0001, 1'b0, 2, 60);
        check("t2_latency", obs_first, 1);
        check("t2_grant0", obs_g[0], 4'b0001);
        check("t2_beats", obs_beats[0], BM);
        check("t2_len", obs_len[0], BM);
        check("t2_regrant", obs_g[1], 4'b0001);
        check("t2_gap", obs_gap[1], 2);
        check("t2_viol", obs_viol, 0);

        // round robin over all consumers with FIFO always valid
        do_reset();
        run_obs(4'b1111, 1'b0, 5, 200);
        for (int i = 0; i < 5; i++) begin
            logic [3:0] expg;
            expg = 4'(1 << (i % NC));
            check($sformatf("t3_grant%0d", i), obs_g[i], expg);
            check($sformatf("t3_beats%0d", i), obs_beats[i], BM);
            if (i > 0) check($sformatf("t3_gap%0d", i), obs_gap[i], 2);
        end
        check("t3_words", obs_beats[0] + obs_beats[1] + obs_beats[2] + obs_beats[3], 64);
        check("t3_viol", obs_viol, 0);

        // empty FIFO mid-burst: grant and count held, no timeout
        do_reset();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            set_in(4'b0010, 1'b1, 4'hF);
            #1;
            if (i == 1) check("t4_grant", bus.o_grant, 4'b0010);
            if (bus.o_fifo_dready && bus.i_fifo_valid) wptr++;
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            set_in(4'b0010, 1'b0, 4'hF);
            #1;
            if (bus.o_fifo_dready !== 1'b1 || bus.o_beat_cnt !== 5'd3 ||
                bus.o_grant !== 4'b0010 || bus.o_cons_valid !== 4'h0) bad++;
        end
        check("t4_hold", bad, 0);
        next_cycle();
        set_in(4'b0010, 1'b1, 4'hF);
        #1;
        check("t4_resume_cnt", bus.o_beat_cnt, 5'd3);
        check("t4_resume_pop", bus.o_fifo_dready & bus.i_fifo_valid, 1'b1);
        wptr++;
        next_cycle();
        #1;
        check("t4_next_cnt", bus.o_beat_cnt, 5'd4);

        // backpressure: ready toggles, 16 beats over 32 granted cycles
        do_reset();
        run_obs(4'b0001, 1'b1, 1, 80);
        check("t5_beats", obs_beats[0], BM);
        check("t5_len", obs_len[0], 2 * BM);
        check("t5_viol", obs_viol, 0);

        // asynchronous reset in the middle of a burst
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            set_in(4'b0001, 1'b1, 4'hF);
            #1;
            if (bus.o_beat_cnt == 5'd5) begin
                hit = 1'b1;
                break;
            end
            if (bus.o_fifo_dready && bus.i_fifo_valid) wptr++;
        end
        check("t1_reach_beat5", hit, 1'b1);
        rd_rst_n = 1'b0;
        #1;
        check_outs("t1_async_reset", 4'h0, 1'b0, 4'h0, 5'd0, 1'b0);
        #2;
        set_in(4'b1111, 1'b1, 4'hF);
        rd_rst_n = 1'b1;
        next_cycle();
        #1;
        check("t1_first_grant", bus.o_grant, 4'b0001);
        $display("reset mid-burst: first grant after release %b", bus.o_grant);

        // randomized run against the grant-session model
        do_reset();
        model_reset();
        reqv = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            if ($urandom_range(0, 7) == 0) reqv = 4'($urandom_range(0, 15));
            fv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            set_in(reqv, fv, rdy);
            #1;
            model_eval(reqv, fv, rdy, eg, ed, ev, ec, eb);
            check_outs("rand", eg, ed, ev, ec, eb);
            if (bus.o_grant != 4'h0) check("rand_data", bus.o_cons_data, bus.i_fifo_data);
            if (bus.o_fifo_dready && fv) wptr++;
            model_step(reqv, fv, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
